// File: rtl/vec_simd_alu_pipe.sv
// Two-stage pipelined packed-SIMD ALU: signed add/sub/mul/mac/min/max per lane
// with optional saturation, per-byte overflow flags and valid/ready on both sides.
module vec_simd_alu_pipe #(
  parameter int DATA_W = 64,
  parameter int FLAG_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [2:0]        operation,
  input  logic [1:0]        num_bits_to_operate,
  input  logic              sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic [FLAG_W-1:0] ovf
);

  localparam int MAX_LANES = DATA_W / 8;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        ew_q, ew_d;
  logic              sat_q, sat_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [FLAG_W-1:0] ovf_q, ovf_d;

  logic              s2_ready, s1_adv, accept;
  logic [DATA_W-1:0] res_vec;
  logic [FLAG_W-1:0] flag_vec;
  logic [64:0]       lane;
  logic [7:0]        byte_mask;
  int                lane_w, n_lanes;

  // One lane of width 8<<ew held in the low bits of 64-bit words; exact math is
  // done at 130 bits so the 64-bit MAC (129 bits) never loses its sign.
  function automatic logic [64:0] lane_op(input logic [63:0] xr, input logic [63:0] yr,
                                          input logic [63:0] zr, input logic [1:0] ew,
                                          input logic [2:0] op, input logic sat_en);
    int                 sh;
    logic signed [63:0]  xs, ys, zs;
    logic signed [129:0] x, y, z, r, hi, lo;
    logic               ov;
    logic [63:0]        res;
    sh = 64 - (8 << ew);
    xs = $signed(xr << sh) >>> sh;
    ys = $signed(yr << sh) >>> sh;
    zs = $signed(zr << sh) >>> sh;
    x  = {{66{xs[63]}}, xs};
    y  = {{66{ys[63]}}, ys};
    z  = {{66{zs[63]}}, zs};
    hi = (130'sd1 <<< ((8 << ew) - 1)) - 130'sd1;
    lo = ~hi;
    case (op)
      3'b000:  r = x + y;
      3'b001:  r = x - y;
      3'b010:  r = x * y;
      3'b011:  r = x * y + z;
      3'b100:  r = (x < y) ? x : y;
      3'b101:  r = (x > y) ? x : y;
      default: r = '0;
    endcase
    ov = (op <= 3'b011) && ((r > hi) || (r < lo));
    if (ov && sat_en) r = r[129] ? lo : hi;
    res = r[63:0] & (~64'd0 >> sh);
    return {ov, res};
  endfunction

  always_comb begin
    s2_ready = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_ready;
    in_ready = !s1_valid_q || s1_adv;
    accept   = in_valid && in_ready;
  end

  // Lane loop runs to the byte-lane count; lanes past the active width are skipped.
  always_comb begin
    lane_w   = 8 << ew_q;
    n_lanes  = DATA_W >> (3 + ew_q);
    res_vec  = '0;
    flag_vec = '0;
    lane     = '0;
    case (ew_q)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
    for (int l = 0; l < MAX_LANES; l++) begin
      if (l < n_lanes) begin
        lane     = lane_op(64'(a_q >> (l * lane_w)), 64'(b_q >> (l * lane_w)),
                           64'(c_q >> (l * lane_w)), ew_q, op_q, sat_q);
        res_vec  = res_vec | (DATA_W'(lane[63:0]) << (l * lane_w));
        flag_vec = flag_vec | (FLAG_W'(lane[64] ? byte_mask : 8'h00) << (l << ew_q));
      end
    end
  end

  always_comb begin
    s1_valid_d  = accept || (s1_valid_q && !s1_adv);
    a_d         = accept ? a : a_q;
    b_d         = accept ? b : b_q;
    c_d         = accept ? c : c_q;
    op_d        = accept ? operation : op_q;
    ew_d        = accept ? num_bits_to_operate : ew_q;
    sat_d       = accept ? sat : sat_q;
    out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
    out_d       = s1_adv ? res_vec : out_q;
    ovf_d       = s1_adv ? flag_vec : ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= '0;
      ew_q        <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      op_q        <= op_d;
      ew_q        <= ew_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vec_simd_alu_pipe.sv
// Directed bench for vec_simd_alu_pipe: a lane-level model feeds an expectation
// queue, and literal vectors pin both the model and the DUT.
module tb_vec_simd_alu_pipe;

   localparam int DW = 64;
   localparam int FW = DW / 8;

   typedef struct {
      logic [DW-1:0] o;
      logic [FW-1:0] f;
   } exp_t;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a, b, c;
   logic [2:0]    operation;
   logic [1:0]    num_bits_to_operate;
   logic          sat;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out;
   logic [FW-1:0] ovf;

   int            nChecks = 0;
   int            nFail = 0;
   int            acceptCount = 0;
   int            nDelivered = 0;
   exp_t          expQ[$];
   logic          prevHold = 1'b0;
   logic [DW-1:0] prevOut;
   logic [FW-1:0] prevOvf;

   vec_simd_alu_pipe #(.DATA_W(DW)) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .a                   (a),
      .b                   (b),
      .c                   (c),
      .operation           (operation),
      .num_bits_to_operate (num_bits_to_operate),
      .sat                 (sat),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out                 (out),
      .ovf                 (ovf)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something deadlocks
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Lane model: bitwise sign extension, exact 130-bit math, and overflow as
   // "the exact result differs from the re-sign-extension of its low w bits"
   function automatic void modelOp(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                   input logic [DW-1:0] cv, input logic [2:0] op,
                                   input logic [1:0] ew, input logic s,
                                   output logic [DW-1:0] res, output logic [FW-1:0] flg);
      int w;
      int lanes;
      logic signed [129:0] x, y, z, r, t;
      logic over;
      w = 8 << ew;
      lanes = DW / w;
      res = '0;
      flg = '0;
      for (int l = 0; l < lanes; l++) begin
         for (int i = 0; i < 130; i++) begin
            x[i] = av[l*w + ((i < w) ? i : w-1)];
            y[i] = bv[l*w + ((i < w) ? i : w-1)];
            z[i] = cv[l*w + ((i < w) ? i : w-1)];
         end
         case (op)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = x * y;
            3'd3:    r = x * y + z;
            3'd4:    r = (x < y) ? x : y;
            3'd5:    r = (x > y) ? x : y;
            default: r = '0;
         endcase
         for (int i = 0; i < 130; i++) t[i] = r[(i < w) ? i : w-1];
         over = (op <= 3'd3) && (t != r);
         for (int i = 0; i < w; i++)
            res[l*w+i] = (over && s) ? ((i == w-1) ? r[129] : ~r[129]) : r[i];
         for (int j = 0; j < w/8; j++) flg[l*(w/8)+j] = over;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      nChecks++;
      if (act !== req) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Offer one transaction and return just after the edge that accepted it
   task automatic applyStimulus(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                input logic [DW-1:0] cv, input logic [2:0] op,
                                input logic [1:0] ew, input logic s);
      bit got;
      a = av;
      b = bv;
      c = cv;
      operation = op;
      num_bits_to_operate = ew;
      sat = s;
      in_valid = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      if (!got) begin
         nChecks++;
         nFail++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
      end
      in_valid = 1'b0;
   endtask

   // Single transaction on an empty pipe with a literal expectation
   task automatic runOne(input string name, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                         input logic [DW-1:0] cv, input logic [2:0] op, input logic [1:0] ew,
                         input logic s, input logic [DW-1:0] expO, input logic [FW-1:0] expF);
      applyStimulus(av, bv, cv, op, ew, s);
      checkOutput({name, "_early"}, DW'(out_valid), DW'(0));
      @(posedge clk);
      #1;
      checkOutput({name, "_valid"}, DW'(out_valid), DW'(1));
      checkOutput({name, "_out"}, out, expO);
      checkOutput({name, "_ovf"}, DW'(ovf), DW'(expF));
   endtask

   // Scoreboard: every handshake is sampled mid-cycle, ahead of the edge that commits it
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         expQ.delete();
         prevHold = 1'b0;
      end else begin
         if (prevHold) begin
            checkOutput("hold_out", out, prevOut);
            checkOutput("hold_ovf", DW'(ovf), DW'(prevOvf));
            checkOutput("hold_valid", DW'(out_valid), DW'(1));
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFail++;
               $display("[TB] FAIL unexpected_output: got %0h, required no result", out);
            end else begin
               e = expQ.pop_front();
               checkOutput("model_out", out, e.o);
               checkOutput("model_ovf", DW'(ovf), DW'(e.f));
               nDelivered++;
            end
         end
         if (in_valid && in_ready) begin
            modelOp(a, b, c, operation, num_bits_to_operate, sat, e.o, e.f);
            expQ.push_back(e);
            acceptCount++;
         end
         prevHold = out_valid && !out_ready;
         prevOut  = out;
         prevOvf  = ovf;
      end
   end

   initial begin
      int deliveredBase;
      rstn = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      c = '0;
      operation = '0;
      num_bits_to_operate = '0;
      sat = 1'b0;

      #12;
      checkOutput("reset_valid", DW'(out_valid), DW'(0));
      checkOutput("reset_out", out, '0);
      checkOutput("reset_ovf", DW'(ovf), DW'(0));
      @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      checkOutput("reset_in_ready", DW'(in_ready), DW'(1));

      runOne("add8_wrap", 64'h7F, 64'h01, 64'h0, 3'b000, 2'd0, 1'b0, 64'h80, 8'h01);
      runOne("add8_sat", 64'h7F, 64'h01, 64'h0, 3'b000, 2'd0, 1'b1, 64'h7F, 8'h01);
      runOne("sub8_sat", 64'h0580, 64'h0701, 64'h0, 3'b001, 2'd0, 1'b1, 64'hFE80, 8'h01);
      runOne("mul16_wrap", 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 64'h0,
             3'b010, 2'd1, 1'b0, 64'h0, 8'hFF);
      runOne("mul16_sat", 64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 64'h0,
             3'b010, 2'd1, 1'b1, 64'h7FFF_7FFF_7FFF_7FFF, 8'hFF);
      runOne("mac32", 64'hFFFF_FFFE_0000_0003, 64'h0000_0005_0000_0004, 64'h0000_0001_0000_0005,
             3'b011, 2'd2, 1'b0, 64'hFFFF_FFF7_0000_0011, 8'h00);
      runOne("add32_sat", 64'h7FFF_FFFF_0000_0001, 64'h0000_0001_0000_0002, 64'h0,
             3'b000, 2'd2, 1'b1, 64'h7FFF_FFFF_0000_0003, 8'hF0);
      runOne("max16", 64'h8000_0001_FFFF_0005, 64'h7FFF_0002_0001_FFFB, 64'h0,
             3'b101, 2'd1, 1'b0, 64'h7FFF_0002_0001_0005, 8'h00);
      runOne("min64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 3'b100, 2'd3, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      runOne("max64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 3'b101, 2'd3, 1'b0, 64'h1, 8'h00);
      runOne("rsvd110", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h5, 3'b110, 2'd3, 1'b1, 64'h0, 8'h00);
      runOne("mul64_wrap", 64'h4000_0000_0000_0000, 64'h2, 64'h0, 3'b010, 2'd3, 1'b0,
             64'h8000_0000_0000_0000, 8'hFF);

      // Backpressure: four back-to-back offers against a stalled output
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      acceptCount = 0;
      deliveredBase = nDelivered;
      fork
         begin
            applyStimulus(64'h0102_0304_0506_0708, 64'h1010_1010_1010_1010, 64'h0, 3'b000, 2'd0, 1'b0);
            applyStimulus(64'h7F7F_7F7F_7F7F_7F7F, 64'h0101_0101_0101_0101, 64'h0, 3'b000, 2'd0, 1'b1);
            applyStimulus(64'h0003_0004_0005_0006, 64'h0002_0002_0002_0002, 64'h0, 3'b010, 2'd1, 1'b0);
            applyStimulus(64'h0000_0010_0000_0020, 64'h0000_0030_0000_0008, 64'h0, 3'b001, 2'd2, 1'b0);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            checkOutput("bp_accepted", DW'(acceptCount), DW'(2));
            checkOutput("bp_in_ready", DW'(in_ready), DW'(0));
            checkOutput("bp_held_out", out, 64'h1112_1314_1516_1718);
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               checkOutput($sformatf("bp_stream%0d", k), DW'(out_valid), DW'(1));
            end
         end
      join
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_delivered", DW'(nDelivered - deliveredBase), DW'(4));

      // Reset with two transactions in flight
      out_ready = 1'b0;
      applyStimulus(64'h11, 64'h22, 64'h0, 3'b000, 2'd0, 1'b0);
      applyStimulus(64'h33, 64'h44, 64'h0, 3'b000, 2'd0, 1'b0);
      checkOutput("rst_pre_valid", DW'(out_valid), DW'(1));
      rstn = 1'b0;
      #1;
      checkOutput("rst_async_valid", DW'(out_valid), DW'(0));
      checkOutput("rst_async_out", out, '0);
      checkOutput("rst_async_ovf", DW'(ovf), DW'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      out_ready = 1'b1;
      runOne("post_rst_add", 64'h01, 64'h01, 64'h0, 3'b000, 2'd0, 1'b0, 64'h02, 8'h00);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("drain_empty", DW'(expQ.size()), DW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
